// File: rtl/jelly_params_bank_loader.sv
// Banked parameter store: a host port writes NUM-word banks into one RAM, and a start streams one bank into params, committing every word on a single edge.
// Latency: busy for NUM+READ_LATENCY cycles per load; params/done update on the last of those edges.
// Backpressure: none; a start while busy is queued one deep (last valid bank wins), and an out-of-range bank pulses err.
// Optional host read-back of the RAM is enabled by defining JELLY_PARAMS_BANK_LOADER_READBACK_EN.
module jelly_params_bank_loader #(
    parameter int                          NUM          = 5,
    parameter int                          DATA_WIDTH   = 32,
    parameter int                          ADDR_WIDTH   = 3,
    parameter int                          BANK_NUM     = 2,
    parameter int                          BANK_WIDTH   = 1,
    parameter int                          READ_LATENCY = 1,
    parameter logic [NUM*DATA_WIDTH-1:0]   INIT_PARAMS  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BANK_WIDTH-1:0]          bank,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [NUM*DATA_WIDTH-1:0]      params,
    input  logic                           mem_en,
    input  logic                           mem_we,
    input  logic [BANK_WIDTH-1:0]          mem_bank,
    input  logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_din,
    output logic [DATA_WIDTH-1:0]          mem_dout
);

    localparam int DEPTH = BANK_NUM * NUM;
    localparam int LIN_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic bank_ok(input logic [BANK_WIDTH-1:0] b);
        return int'(b) < BANK_NUM;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < NUM;
    endfunction

    function automatic logic [LIN_W-1:0] lin(input logic [BANK_WIDTH-1:0] b,
                                             input logic [ADDR_WIDTH-1:0] a);
        return LIN_W'(int'(b) * NUM + int'(a));
    endfunction

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      rd_idx, rd_idx_next;
    logic                       drain_cnt, drain_cnt_next;
    logic [BANK_WIDTH-1:0]      load_bank, load_bank_next;
    logic                       pend, pend_next;
    logic [BANK_WIDTH-1:0]      pend_bank, pend_bank_next;
    logic                       done_next, err_next;
    logic                       rd_issue;
    logic                       commit;
    logic                       start_ok;
    logic                       wr_ok;

    logic [DATA_WIDTH-1:0]      ram_q;
    logic                       p1_vld;
    logic [ADDR_WIDTH-1:0]      p1_idx;
    logic                       ret_vld;
    logic [ADDR_WIDTH-1:0]      ret_idx;
    logic [DATA_WIDTH-1:0]      ret_dat;

    logic [NUM*DATA_WIDTH-1:0]  staging, staging_next;

    assign start_ok = start && bank_ok(bank);
    assign wr_ok    = mem_en && mem_we && bank_ok(mem_bank) && addr_ok(mem_addr);
    assign commit   = (state == ST_DRAIN) && (drain_cnt == 1'(READ_LATENCY - 1));
    assign busy     = (state != ST_IDLE);

    // RAM array: host writes plus the load read port; read-first on a same-word collision
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[lin(mem_bank, mem_addr)] <= mem_din;
        end
        if (rd_issue) begin
            ram_q <= mem[lin(load_bank, rd_idx)];
        end
    end

    // Tag each load read with its word index so returns can be placed in staging
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld <= 1'b0;
            p1_idx <= '0;
        end else begin
            p1_vld <= rd_issue;
            p1_idx <= rd_idx;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  p2_vld;
            logic [ADDR_WIDTH-1:0] p2_idx;
            logic [DATA_WIDTH-1:0] p2_dat;

            // Extra output register stage on the load read path
            always_ff @(posedge clk) begin
                if (reset) begin
                    p2_vld <= 1'b0;
                    p2_idx <= '0;
                end else begin
                    p2_vld <= p1_vld;
                    p2_idx <= p1_idx;
                end
                p2_dat <= ram_q;
            end

            assign ret_vld = p2_vld;
            assign ret_idx = p2_idx;
            assign ret_dat = p2_dat;
        end else begin : g_lat1
            assign ret_vld = p1_vld;
            assign ret_idx = p1_idx;
            assign ret_dat = ram_q;
        end
    endgenerate

    // Staging view including the word returning this cycle, so the last word can commit on arrival
    always_comb begin
        staging_next = staging;
        if (ret_vld) begin
            staging_next[int'(ret_idx)*DATA_WIDTH +: DATA_WIDTH] = ret_dat;
        end
    end

    // Staging register; every word is rewritten before each commit, so it needs no reset
    always_ff @(posedge clk) begin
        staging <= staging_next;
    end

    // Next-state logic: read sequencing, pending-start queue, reject of invalid banks
    always_comb begin
        state_next     = state;
        rd_idx_next    = rd_idx;
        drain_cnt_next = drain_cnt;
        load_bank_next = load_bank;
        pend_next      = pend;
        pend_bank_next = pend_bank;
        done_next      = 1'b0;
        err_next       = 1'b0;
        rd_issue       = 1'b0;

        if (state == ST_IDLE) begin
            if (start_ok) begin
                state_next     = ST_READ;
                rd_idx_next    = '0;
                load_bank_next = bank;
            end else if (start) begin
                err_next = 1'b1;
            end
        end else begin
            if (start_ok) begin
                pend_next      = 1'b1;
                pend_bank_next = bank;
            end else if (start) begin
                err_next = 1'b1;
            end

            if (state == ST_READ) begin
                rd_issue = 1'b1;
                if (rd_idx == ADDR_WIDTH'(NUM - 1)) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 1'b0;
                end else begin
                    rd_idx_next = rd_idx + ADDR_WIDTH'(1);
                end
            end else if (commit) begin
                done_next = 1'b1;
                pend_next = 1'b0;
                if (pend || start_ok) begin
                    // Chain straight into the queued load with no idle cycle
                    state_next     = ST_READ;
                    rd_idx_next    = '0;
                    load_bank_next = start_ok ? bank : pend_bank;
                end else begin
                    state_next = ST_IDLE;
                end
            end else begin
                drain_cnt_next = drain_cnt + 1'b1;
            end
        end
    end

    // Control state, pulses and the committed parameter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_idx    <= '0;
            drain_cnt <= 1'b0;
            load_bank <= '0;
            pend      <= 1'b0;
            pend_bank <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            params    <= INIT_PARAMS;
        end else begin
            state     <= state_next;
            rd_idx    <= rd_idx_next;
            drain_cnt <= drain_cnt_next;
            load_bank <= load_bank_next;
            pend      <= pend_next;
            pend_bank <= pend_bank_next;
            done      <= done_next;
            err       <= err_next;
            if (commit) begin
                params <= staging_next;
            end
        end
    end

`ifdef JELLY_PARAMS_BANK_LOADER_READBACK_EN
    logic [DATA_WIDTH-1:0] hr_q;

    // Host read port: out-of-range addresses read as zero; value holds until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            hr_q <= '0;
        end else if (mem_en && !mem_we) begin
            hr_q <= (bank_ok(mem_bank) && addr_ok(mem_addr)) ? mem[lin(mem_bank, mem_addr)] : '0;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_hr_lat2
            logic [DATA_WIDTH-1:0] hr_q2;

            // Output register stage for the host read path
            always_ff @(posedge clk) begin
                if (reset) begin
                    hr_q2 <= '0;
                end else begin
                    hr_q2 <= hr_q;
                end
            end

            assign mem_dout = hr_q2;
        end else begin : g_hr_lat1
            assign mem_dout = hr_q;
        end
    endgenerate
`else
    assign mem_dout = '0;
`endif

endmodule

// File: tb/tb_jelly_params_bank_loader.sv
// Bench for jelly_params_bank_loader: two instances (read latency 1 and 2) share one stimulus stream.
// A behavioural model tracks both; every cycle all outputs are compared against it.
// Directed literal checks pin busy length, done count, err timing, reset abort and collision handling.
module tb_jelly_params_bank_loader;

    localparam int NUM = 5;
    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int BN  = 2;
    localparam int BW  = 2;
    localparam int PW  = NUM * DW;
    localparam logic [PW-1:0] INIT = {32'h0000_00A5, 32'h0000_00A4, 32'h0000_00A3,
                                      32'h0000_00A2, 32'h0000_00A1};
    localparam logic [PW-1:0] BANK0 = {32'h0105, 32'h0104, 32'h0103, 32'h0102, 32'h0101};
    localparam logic [PW-1:0] BANK1 = {32'h0205, 32'h0204, 32'h0203, 32'h0202, 32'h0201};

    logic            clk;
    logic            reset;
    logic            start;
    logic [BW-1:0]   bank;
    logic            mem_en;
    logic            mem_we;
    logic [BW-1:0]   mem_bank;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;

    logic            busy_o   [2];
    logic            done_o   [2];
    logic            err_o    [2];
    logic [PW-1:0]   params_o [2];
    logic [DW-1:0]   dout_o   [2];

    int n_chk  = 0;
    int n_fail = 0;

    jelly_params_bank_loader #(
        .NUM(NUM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_NUM(BN), .BANK_WIDTH(BW),
        .READ_LATENCY(1), .INIT_PARAMS(INIT)
    ) u_lat1 (
        .clk(clk), .reset(reset), .start(start), .bank(bank),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .params(params_o[0]),
        .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(dout_o[0])
    );

    jelly_params_bank_loader #(
        .NUM(NUM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_NUM(BN), .BANK_WIDTH(BW),
        .READ_LATENCY(2), .INIT_PARAMS(INIT)
    ) u_lat2 (
        .clk(clk), .reset(reset), .start(start), .bank(bank),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .params(params_o[1]),
        .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(dout_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is "cycles since accepted": word k is sampled from the RAM at the (k+1)th edge,
    // all words appear in params at edge NUM+latency, and a queued start begins at that same edge.
    logic [DW-1:0] m_mem [BN*NUM];
    logic          m_busy [2];
    int            m_cnt  [2];
    int            m_lb   [2];
    logic          m_pend [2];
    int            m_pb   [2];
    logic          m_done [2];
    logic          m_err  [2];
    logic [PW-1:0] m_par  [2];
    logic [PW-1:0] m_stg  [2];
    logic [DW-1:0] m_rb1  [2];
    logic [DW-1:0] m_rb2  [2];

    task automatic model_step();
        logic sv;
        logic rd_in;
        sv    = start && (int'(bank) < BN);
        rd_in = (int'(mem_bank) < BN) && (int'(mem_addr) < NUM);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 1'b0; m_cnt[i] = 0; m_pend[i] = 1'b0;
                m_done[i] = 1'b0; m_err[i] = 1'b0; m_par[i] = INIT;
                m_rb1[i] = '0; m_rb2[i] = '0;
            end else begin
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
                if (m_busy[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] <= NUM)
                        m_stg[i][(m_cnt[i]-1)*DW +: DW] = m_mem[m_lb[i]*NUM + m_cnt[i] - 1];
                    if (sv) begin
                        m_pend[i] = 1'b1; m_pb[i] = int'(bank);
                    end else if (start) begin
                        m_err[i] = 1'b1;
                    end
                    if (m_cnt[i] == NUM + i + 1) begin
                        m_par[i]  = m_stg[i];
                        m_done[i] = 1'b1;
                        if (m_pend[i]) begin
                            m_cnt[i] = 0; m_lb[i] = m_pb[i]; m_pend[i] = 1'b0;
                        end else begin
                            m_busy[i] = 1'b0;
                        end
                    end
                end else if (sv) begin
                    m_busy[i] = 1'b1; m_cnt[i] = 0; m_lb[i] = int'(bank);
                end else if (start) begin
                    m_err[i] = 1'b1;
                end
`ifdef JELLY_PARAMS_BANK_LOADER_READBACK_EN
                m_rb2[i] = m_rb1[i];
                if (mem_en && !mem_we)
                    m_rb1[i] = rd_in ? m_mem[int'(mem_bank)*NUM + int'(mem_addr)] : '0;
`endif
            end
        end
        if (mem_en && mem_we && rd_in)
            m_mem[int'(mem_bank)*NUM + int'(mem_addr)] = mem_din;
    endtask

    // Model advance and full output compare, 1 time unit after every rising edge
    initial begin
        int steps;
        steps = 0;
        forever begin
            @(posedge clk);
            #1;
            model_step();
            if (steps > 0) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("busy%0d", i),   PW'(busy_o[i]), PW'(m_busy[i]));
                    chk($sformatf("done%0d", i),   PW'(done_o[i]), PW'(m_done[i]));
                    chk($sformatf("err%0d", i),    PW'(err_o[i]),  PW'(m_err[i]));
                    chk($sformatf("params%0d", i), params_o[i],    m_par[i]);
                    chk($sformatf("dout%0d", i),   PW'(dout_o[i]), PW'(i == 0 ? m_rb1[i] : m_rb2[i]));
                end
            end
            steps++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic idle_inputs();
        start = 1'b0; bank = '0; mem_en = 1'b0; mem_we = 1'b0;
        mem_bank = '0; mem_addr = '0; mem_din = '0;
    endtask

    task automatic host_write(input int b, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b1; mem_bank = BW'(b); mem_addr = AW'(a); mem_din = d;
        @(negedge clk);
        mem_en = 1'b0; mem_we = 1'b0;
    endtask

    // Pulse start for one cycle, then count busy/done cycles until both instances are idle
    task automatic load_and_count(input int b, output int b1, output int b2, output int d1, output int d2);
        b1 = 0; b2 = 0; d1 = 0; d2 = 0;
        @(negedge clk);
        start = 1'b1; bank = BW'(b);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            b1 += int'(busy_o[0]); b2 += int'(busy_o[1]);
            d1 += int'(done_o[0]); d2 += int'(done_o[1]);
            if (!busy_o[0] && !busy_o[1]) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        while ((busy_o[0] || busy_o[1]) && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_idle_timeout"}, PW'(c < 60), PW'(1));
        @(negedge clk);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int b1, b2, d1, d2, dc;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_params", params_o[0], INIT);
        chk("reset_busy", PW'(busy_o[1]), PW'(0));

        for (int b = 0; b < BN; b++)
            for (int a = 0; a < NUM; a++)
                host_write(b, a, DW'(32'h0100 * (b + 1) + a + 1));
        // Out-of-range writes; bank0/addr5 would alias bank1 word0 if not rejected
        host_write(2, 0, 32'hDEAD_0001);
        host_write(0, 5, 32'hDEAD_0002);
        host_write(1, 7, 32'hDEAD_0003);

        load_and_count(0, b1, b2, d1, d2);
        chk("busy_len_lat1", PW'(b1), PW'(6));
        chk("busy_len_lat2", PW'(b2), PW'(7));
        chk("done_cnt_lat1", PW'(d1), PW'(1));
        chk("load0_params_lat1", params_o[0], BANK0);
        chk("load0_params_lat2", params_o[1], BANK0);

        // Chained loads: bank1 then two requests while busy, last one (bank1) wins
        @(negedge clk); start = 1'b1; bank = 2'd1;
        @(negedge clk); bank = 2'd0;
        @(negedge clk); bank = 2'd1;
        @(negedge clk); start = 1'b0;
        dc = 0;
        for (int c = 0; c < 60 && (busy_o[0] || busy_o[1] || c < 2); c++) begin
            dc += int'(done_o[0]);
            @(negedge clk);
        end
        dc += int'(done_o[0]);
        chk("chain_done_cnt", PW'(dc), PW'(2));
        chk("chain_params_lat1", params_o[0], BANK1);
        chk("chain_params_lat2", params_o[1], BANK1);

        // Invalid bank: err one cycle later, nothing else moves
        @(negedge clk); start = 1'b1; bank = 2'd3;
        @(negedge clk); start = 1'b0;
        chk("bad_bank_err", PW'(err_o[0]), PW'(1));
        chk("bad_bank_busy", PW'(busy_o[0]), PW'(0));
        @(negedge clk);
        chk("bad_bank_err_clear", PW'(err_o[1]), PW'(0));
        chk("bad_bank_params", params_o[0], BANK1);

        // Reset while reading address 2
        @(negedge clk); start = 1'b1; bank = 2'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("abort_busy", PW'(busy_o[0]), PW'(0));
        chk("abort_params", params_o[1], INIT);
        load_and_count(0, b1, b2, d1, d2);
        chk("after_abort_params", params_o[0], BANK0);

        // Host write to word 0 on the same edge it is read by the load: load keeps old data
        @(negedge clk); start = 1'b1; bank = 2'd0;
        @(negedge clk); start = 1'b0;
        mem_en = 1'b1; mem_we = 1'b1; mem_bank = 2'd0; mem_addr = 3'd0; mem_din = 32'h0999;
        @(negedge clk); mem_en = 1'b0; mem_we = 1'b0;
        wait_idle("collide");
        chk("collide_word0", params_o[0], BANK0);
        host_write(0, 0, 32'h0101);

`ifdef JELLY_PARAMS_BANK_LOADER_READBACK_EN
        @(negedge clk); mem_en = 1'b1; mem_we = 1'b0; mem_bank = 2'd1; mem_addr = 3'd4;
        @(negedge clk); mem_en = 1'b0;
        chk("readback_lat1", PW'(dout_o[0]), PW'(32'h0205));
        @(negedge clk);
        chk("readback_lat2", PW'(dout_o[1]), PW'(32'h0205));
`else
        @(negedge clk); mem_en = 1'b1; mem_we = 1'b0; mem_bank = 2'd1; mem_addr = 3'd4;
        @(negedge clk); mem_en = 1'b0;
        @(negedge clk);
        chk("readback_off", PW'(dout_o[1]), PW'(0));
`endif

        // Randomised traffic: starts (incl. invalid banks), host writes/reads, rare resets
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 6) == 0);
            bank     = BW'($urandom_range(0, 3));
            mem_en   = ($urandom_range(0, 2) == 0);
            mem_we   = $urandom_range(0, 1) == 1;
            mem_bank = BW'($urandom_range(0, 3));
            mem_addr = AW'($urandom_range(0, 7));
            mem_din  = $urandom;
            reset    = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        wait_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
